recv_packet: RTL and testbench
==============================

Name: recv_packet

Overview:
- Parametrised successor to the fixed-length multi-frame receiver.
- Contains its own UART bit engine: 8N1-style, LSB-first, start/stop framing.
- Runtime-selectable packet length (1..MAX_FRAMES frames), selectable frame order, stop-bit framing-error detection and inter-frame timeout.
- Sits between the rx_in pin and the command/weight loaders that consume whole packets.

Parameters:
- CLK_BAUD_RATIO, 25: clock cycles per bit, must be >= 4.
- FRAME_SIZE, 8: data bits per frame.
- MAX_FRAMES, 4: maximum frames per packet. DATA_SIZE = FRAME_SIZE*MAX_FRAMES.
- TIMEOUT_BITS, 32: idle bit periods allowed between frames once a packet has started.
- MSB_FRAME_FIRST, 0: 0 = frame k lands at bits [k*FRAME_SIZE +: FRAME_SIZE]; 1 = first frame lands in the top slot of the requested length.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-high
- receive_in  input  1  arm request, sampled only when not busy
- len_in  input  $clog2(MAX_FRAMES+1)  frames requested, latched with receive_in
- rx_in  input  1  asynchronous serial line, idles high
- data_out  output  DATA_SIZE  assembled packet
- len_out  output  $clog2(MAX_FRAMES+1)  frames actually captured in data_out
- new_data_out  output  1  one-cycle pulse, data_out/len_out valid
- busy_out  output  1  high from arm until completion or abort
- frame_err_out  output  1  one-cycle pulse, stop bit sampled low
- timeout_out  output  1  one-cycle pulse, inter-frame timeout

Behaviour:
- Reset: all outputs 0, counters 0, both FSMs IDLE, synchroniser flops loaded with 1. Reset mid-packet discards everything; no pulses are issued.
- rx_in passes through a 2-flop synchroniser. All timing below is relative to the synchronised signal.
- Bit engine FSM: B_IDLE -> B_START -> B_DATA -> B_STOP -> B_IDLE.
  - B_IDLE: a falling edge enters B_START and clears the cycle counter.
  - B_START: samples at count CLK_BAUD_RATIO/2. Line high = glitch, return to B_IDLE with no pulse.
  - B_DATA: samples FRAME_SIZE bits, each CLK_BAUD_RATIO cycles after the previous sample, LSB first.
  - B_STOP: samples one more bit period later. High = frame good; low = framing error.
  - The engine runs regardless of busy_out. Frames completed while not busy are dropped silently.
- Packet FSM: IDLE -> ARMED -> COLLECT -> IDLE.
  - IDLE and receive_in=1: latch len. len_in of 0 or > MAX_FRAMES is clamped to MAX_FRAMES. Clear the assembly buffer to 0, busy_out <= 1, go to ARMED.
  - receive_in while busy is ignored. ARMED never times out.
  - On each good frame: write the frame into slot k (or slot len-1-k when MSB_FRAME_FIRST=1), increment k, go to COLLECT, reload the timeout counter to TIMEOUT_BITS*CLK_BAUD_RATIO.
  - Completion: the cycle after the stop sample of frame len-1:
    - data_out <= buffer, len_out <= len
    - new_data_out = 1 for one cycle
    - busy_out <= 0, return to IDLE.
  - Frame error while ARMED/COLLECT: frame discarded, frame_err_out pulses, packet aborted (busy_out <= 0). data_out and len_out are unchanged; new_data_out is not asserted.
  - Timeout: COLLECT, bit engine in B_IDLE, counter reaches 0:
    - data_out <= partial buffer, unfilled slots 0
    - len_out <= k
    - timeout_out and new_data_out pulse together
    - busy_out <= 0.
  - The counter only decrements while the bit engine is in B_IDLE.
- Completion latency: new_data_out rises exactly 1 cycle after the final stop sample. For the final frame, that sample falls 2 + CLK_BAUD_RATIO/2 + (FRAME_SIZE+1)*CLK_BAUD_RATIO cycles after the raw rx_in falling edge (2 cycles synchroniser, 1 edge detect folded in).
- Simultaneous events:
  - A completion and receive_in in the same cycle: receive_in is ignored, since busy is still 1 that cycle.
  - A frame whose start bit is already in progress when receive_in arrives is not captured.
- data_out and len_out hold their values between packets.
- All pulse outputs are mutually exclusive except timeout_out with new_data_out.

Test Plan:
- len_in=2, send 0x3C then 0xA5 at 25 clk/bit -> one new_data_out pulse, data_out[15:0]=0xA53C, upper bits 0, len_out=2, busy_out low the same cycle.
- MSB_FRAME_FIRST=1, len_in=3, send 0x01,0x02,0x03 -> data_out[23:0]=0x010203, len_out=3.
- len_in=0, then 4 frames 0x11,0x22,0x33,0x44 -> clamped to 4, data_out=0x44332211; a 5th frame afterwards produces no pulse.
- len_in=4, send 0x11,0x22 then idle for 33 bit periods -> timeout_out and new_data_out pulse, data_out=0x00002211, len_out=2.
- len_in=2, second frame sent with stop bit low -> frame_err_out pulses, busy_out drops, no new_data_out, data_out unchanged from the prior packet.
- 5-cycle low glitch on rx_in while ARMED -> no frame captured. Then rst_in asserted mid-frame -> all outputs 0, no pulses, next packet received correctly.

Source files
------------

// File: rtl/recv_packet.sv
// Multi-frame UART packet receiver: 2-flop synchroniser, LSB-first bit engine,
// and a packet assembler with runtime length, frame ordering, framing-error and timeout handling.
module recv_packet #(
  parameter int unsigned CLK_BAUD_RATIO  = 25,
  parameter int unsigned FRAME_SIZE      = 8,
  parameter int unsigned MAX_FRAMES      = 4,
  parameter int unsigned TIMEOUT_BITS    = 32,
  parameter bit          MSB_FRAME_FIRST = 1'b0
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                receive_in,
  input  logic [$clog2(MAX_FRAMES+1)-1:0]     len_in,
  input  logic                                rx_in,
  output logic [FRAME_SIZE*MAX_FRAMES-1:0]    data_out,
  output logic [$clog2(MAX_FRAMES+1)-1:0]     len_out,
  output logic                                new_data_out,
  output logic                                busy_out,
  output logic                                frame_err_out,
  output logic                                timeout_out
);

  localparam int unsigned DATA_SIZE  = FRAME_SIZE * MAX_FRAMES;
  localparam int unsigned LEN_W      = $clog2(MAX_FRAMES + 1);
  localparam int unsigned CNT_W      = $clog2(CLK_BAUD_RATIO);
  localparam int unsigned BIT_W      = $clog2(FRAME_SIZE + 1);
  localparam int unsigned HALF       = CLK_BAUD_RATIO / 2;
  localparam int unsigned TMO_RELOAD = TIMEOUT_BITS * CLK_BAUD_RATIO;
  localparam int unsigned TMO_W      = $clog2(TMO_RELOAD + 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
  typedef enum logic [1:0] {P_IDLE, P_ARMED, P_COLLECT} pstate_t;

  bstate_t                 bstate_q;
  pstate_t                 pstate_q;
  logic                    rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BIT_W-1:0]        bidx_q;
  logic [FRAME_SIZE-1:0]   shift_q;
  logic                    frm_good_q, frm_bad_q;
  logic [LEN_W-1:0]        len_q, k_q;
  logic [DATA_SIZE-1:0]    buf_q;
  logic [TMO_W-1:0]        tmo_q;
  logic                    skip_q;

  logic [LEN_W-1:0]        len_clamp_d, k_inc_d, slot_d;
  logic [DATA_SIZE-1:0]    buf_ins_d;

  // Bit engine: start-bit centre check, then one sample per bit period.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      bstate_q   <= B_IDLE;
      cnt_q      <= '0;
      bidx_q     <= '0;
      shift_q    <= '0;
      frm_good_q <= 1'b0;
      frm_bad_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx_in;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      frm_good_q <= 1'b0;
      frm_bad_q  <= 1'b0;
      case (bstate_q)
        B_IDLE: begin
          if (!rx_sync_q && rx_prev_q) begin
            bstate_q <= B_START;
            cnt_q    <= '0;
          end
        end
        B_START: begin
          if (cnt_q == CNT_W'(HALF - 1)) begin
            cnt_q    <= '0;
            bidx_q   <= '0;
            bstate_q <= rx_sync_q ? B_IDLE : B_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        B_DATA: begin
          if (cnt_q == CNT_W'(CLK_BAUD_RATIO - 1)) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[FRAME_SIZE-1:1]};
            if (bidx_q == BIT_W'(FRAME_SIZE - 1)) bstate_q <= B_STOP;
            else                                  bidx_q   <= bidx_q + BIT_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        B_STOP: begin
          if (cnt_q == CNT_W'(CLK_BAUD_RATIO - 1)) begin
            cnt_q      <= '0;
            bstate_q   <= B_IDLE;
            frm_good_q <= rx_sync_q;
            frm_bad_q  <= !rx_sync_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: bstate_q <= B_IDLE;
      endcase
    end
  end

  assign len_clamp_d = (len_in == '0 || len_in > LEN_W'(MAX_FRAMES)) ? LEN_W'(MAX_FRAMES) : len_in;
  assign k_inc_d     = k_q + LEN_W'(1);
  assign slot_d      = MSB_FRAME_FIRST ? LEN_W'(len_q - LEN_W'(1) - k_q) : k_q;

  // Assembly buffer with the just-received frame dropped into its slot.
  always_comb begin
    buf_ins_d = buf_q;
    for (int unsigned s = 0; s < MAX_FRAMES; s++) begin
      if (slot_d == LEN_W'(s)) buf_ins_d[s*FRAME_SIZE +: FRAME_SIZE] = shift_q;
    end
  end

  // Packet assembler; skip_q drops a frame whose start bit preceded the arm.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pstate_q      <= P_IDLE;
      len_q         <= '0;
      k_q           <= '0;
      buf_q         <= '0;
      tmo_q         <= '0;
      skip_q        <= 1'b0;
      data_out      <= '0;
      len_out       <= '0;
      new_data_out  <= 1'b0;
      busy_out      <= 1'b0;
      frame_err_out <= 1'b0;
      timeout_out   <= 1'b0;
    end else begin
      new_data_out  <= 1'b0;
      frame_err_out <= 1'b0;
      timeout_out   <= 1'b0;
      if (bstate_q == B_IDLE && tmo_q != '0) tmo_q <= tmo_q - TMO_W'(1);
      case (pstate_q)
        P_IDLE: begin
          if (receive_in) begin
            len_q    <= len_clamp_d;
            k_q      <= '0;
            buf_q    <= '0;
            busy_out <= 1'b1;
            skip_q   <= (bstate_q != B_IDLE);
            pstate_q <= P_ARMED;
          end
        end
        P_ARMED, P_COLLECT: begin
          if (skip_q) begin
            if (frm_good_q || frm_bad_q || bstate_q == B_IDLE) skip_q <= 1'b0;
          end else if (frm_bad_q) begin
            frame_err_out <= 1'b1;
            busy_out      <= 1'b0;
            pstate_q      <= P_IDLE;
          end else if (frm_good_q) begin
            tmo_q <= TMO_W'(TMO_RELOAD);
            k_q   <= k_inc_d;
            if (k_inc_d == len_q) begin
              data_out     <= buf_ins_d;
              len_out      <= len_q;
              new_data_out <= 1'b1;
              busy_out     <= 1'b0;
              pstate_q     <= P_IDLE;
            end else begin
              buf_q    <= buf_ins_d;
              pstate_q <= P_COLLECT;
            end
          end else if (pstate_q == P_COLLECT && bstate_q == B_IDLE && tmo_q == '0) begin
            data_out     <= buf_q;
            len_out      <= k_q;
            new_data_out <= 1'b1;
            timeout_out  <= 1'b1;
            busy_out     <= 1'b0;
            pstate_q     <= P_IDLE;
          end
        end
        default: pstate_q <= P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recv_packet.sv
// Bench for recv_packet: LSB-first and MSB-first instances share one serial line,
// each checked against a packet-level reference model.
module tb_recv_packet;

  localparam int unsigned CBR = 25;
  localparam int unsigned FS  = 8;
  localparam int unsigned MF  = 4;
  localparam int unsigned TB  = 32;
  localparam int unsigned DW  = FS * MF;
  localparam int unsigned LW  = $clog2(MF + 1);
  // Drive lands one edge before the first sampling edge; pulse is one cycle after the stop sample.
  localparam int LAT = 2 + CBR/2 + (FS+1)*CBR + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          receive = 1'b0;
  logic [LW-1:0] len_in = '0;
  logic          rx = 1'b1;

  logic [DW-1:0] data_o [2];
  logic [LW-1:0] len_o  [2];
  logic          nd [2], busy [2], fe [2], to [2];

  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  int nd_cnt [2], fe_cnt [2], to_cnt [2], nd_busy_hi [2], excl_bad [2], nd_cyc [2];
  logic [DW-1:0] nd_data [2];
  logic [LW-1:0] nd_len  [2];
  logic [DW-1:0] exp_last [2];
  logic [LW-1:0] exp_len_last;
  int start_cyc;
  logic [7:0] pkt [8];

  recv_packet #(.CLK_BAUD_RATIO(CBR), .FRAME_SIZE(FS), .MAX_FRAMES(MF), .TIMEOUT_BITS(TB),
                .MSB_FRAME_FIRST(1'b0)) u_lsb (
    .clk_in(clk), .rst_in(rst), .receive_in(receive), .len_in(len_in), .rx_in(rx),
    .data_out(data_o[0]), .len_out(len_o[0]), .new_data_out(nd[0]), .busy_out(busy[0]),
    .frame_err_out(fe[0]), .timeout_out(to[0]));

  recv_packet #(.CLK_BAUD_RATIO(CBR), .FRAME_SIZE(FS), .MAX_FRAMES(MF), .TIMEOUT_BITS(TB),
                .MSB_FRAME_FIRST(1'b1)) u_msb (
    .clk_in(clk), .rst_in(rst), .receive_in(receive), .len_in(len_in), .rx_in(rx),
    .data_out(data_o[1]), .len_out(len_o[1]), .new_data_out(nd[1]), .busy_out(busy[1]),
    .frame_err_out(fe[1]), .timeout_out(to[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder, sampled 1 time unit after each edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      nd_cnt[i] = 0; fe_cnt[i] = 0; to_cnt[i] = 0; nd_busy_hi[i] = 0; excl_bad[i] = 0; nd_cyc[i] = 0;
      nd_data[i] = '0; nd_len[i] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (nd[i]) begin
          nd_cnt[i] = nd_cnt[i] + 1;
          nd_data[i] = data_o[i];
          nd_len[i] = len_o[i];
          nd_cyc[i] = cyc;
          if (busy[i]) nd_busy_hi[i] = nd_busy_hi[i] + 1;
          if (fe[i]) excl_bad[i] = excl_bad[i] + 1;
        end
        if (fe[i]) fe_cnt[i] = fe_cnt[i] + 1;
        if (to[i]) begin
          to_cnt[i] = to_cnt[i] + 1;
          if (!nd[i]) excl_bad[i] = excl_bad[i] + 1;
        end
      end
    end
  end

  function automatic int clamp_len(input int req);
    return (req == 0 || req > int'(MF)) ? int'(MF) : req;
  endfunction

  // Packet-level model: frame k goes to slot k, or slot L-1-k for MSB-first.
  function automatic logic [DW-1:0] model_data(input bit msb, input int req, input int n,
                                               input logic [7:0] fr [8]);
    int l, cap, slot;
    logic [DW-1:0] r;
    l = clamp_len(req);
    cap = (n < l) ? n : l;
    r = '0;
    for (int k = 0; k < cap; k++) begin
      slot = msb ? (l - 1 - k) : k;
      r = r | (DW'(fr[k]) << (FS * slot));
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic arm(input int l);
    receive = 1'b1;
    len_in = LW'(l);
    tick(1);
    receive = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    start_cyc = cyc;
    tick(CBR);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CBR);
    end
    rx = stop_ok;
    tick(CBR);
    rx = 1'b1;
  endtask

  task automatic send_pkt(input int n);
    for (int k = 0; k < n; k++) begin
      send_frame(pkt[k], 1'b1);
      tick($urandom_range(0, CBR));
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx = 1'b1;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 6;
      if (data_o[i] !== '0) begin n_err++; $display("FAIL reset_data[%0d] got %h want 0", i, data_o[i]); end
      if (len_o[i] !== '0) begin n_err++; $display("FAIL reset_len[%0d] got %0d want 0", i, len_o[i]); end
      if (nd[i] !== 1'b0) begin n_err++; $display("FAIL reset_nd[%0d] got %b want 0", i, nd[i]); end
      if (busy[i] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d] got %b want 0", i, busy[i]); end
      if (fe[i] !== 1'b0) begin n_err++; $display("FAIL reset_fe[%0d] got %b want 0", i, fe[i]); end
      if (to[i] !== 1'b0) begin n_err++; $display("FAIL reset_to[%0d] got %b want 0", i, to[i]); end
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic;
    int nd0 [2];
    logic [DW-1:0] e;
    for (int i = 0; i < 2; i++) nd0[i] = nd_cnt[i];
    pkt[0] = 8'h3C; pkt[1] = 8'hA5;
    arm(2);
    n_cmp += 2;
    if (busy[0] !== 1'b1) begin n_err++; $display("FAIL basic_busy_arm[0] got %b want 1", busy[0]); end
    if (busy[1] !== 1'b1) begin n_err++; $display("FAIL basic_busy_arm[1] got %b want 1", busy[1]); end
    send_frame(pkt[0], 1'b1);
    arm(1);
    send_frame(pkt[1], 1'b1);
    tick(4);
    for (int i = 0; i < 2; i++) begin
      e = model_data(i == 1, 2, 2, pkt);
      exp_last[i] = e;
      n_cmp += 6;
      if (nd_cnt[i] - nd0[i] != 1) begin n_err++; $display("FAIL basic_pulses[%0d] got %0d want 1", i, nd_cnt[i] - nd0[i]); end
      if (nd_data[i] !== e) begin n_err++; $display("FAIL basic_data[%0d] got %h want %h", i, nd_data[i], e); end
      if (nd_len[i] !== LW'(2)) begin n_err++; $display("FAIL basic_len[%0d] got %0d want 2", i, nd_len[i]); end
      if (nd_busy_hi[i] != 0) begin n_err++; $display("FAIL basic_busy_at_pulse[%0d] got %0d want 0", i, nd_busy_hi[i]); end
      if (nd_cyc[i] - start_cyc != LAT) begin n_err++; $display("FAIL basic_latency[%0d] got %0d want %0d", i, nd_cyc[i] - start_cyc, LAT); end
      if (busy[i] !== 1'b0) begin n_err++; $display("FAIL basic_busy_after[%0d] got %b want 0", i, busy[i]); end
    end
    exp_len_last = LW'(2);
    n_cmp++;
    if (nd_data[0] !== 32'h0000A53C) begin n_err++; $display("FAIL basic_const got %h want 0000a53c", nd_data[0]); end
  endtask

  task automatic test_msb_len3;
    int nd0 [2];
    logic [DW-1:0] e;
    for (int i = 0; i < 2; i++) nd0[i] = nd_cnt[i];
    pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03;
    arm(3);
    send_pkt(3);
    tick(2);
    for (int i = 0; i < 2; i++) begin
      e = model_data(i == 1, 3, 3, pkt);
      exp_last[i] = e;
      n_cmp += 3;
      if (nd_cnt[i] - nd0[i] != 1) begin n_err++; $display("FAIL msb3_pulses[%0d] got %0d want 1", i, nd_cnt[i] - nd0[i]); end
      if (nd_data[i] !== e) begin n_err++; $display("FAIL msb3_data[%0d] got %h want %h", i, nd_data[i], e); end
      if (nd_len[i] !== LW'(3)) begin n_err++; $display("FAIL msb3_len[%0d] got %0d want 3", i, nd_len[i]); end
    end
    exp_len_last = LW'(3);
    n_cmp++;
    if (nd_data[1] !== 32'h00010203) begin n_err++; $display("FAIL msb3_const got %h want 00010203", nd_data[1]); end
  endtask

  task automatic test_clamp;
    int nd0 [2], fe0 [2];
    logic [DW-1:0] e;
    for (int i = 0; i < 2; i++) nd0[i] = nd_cnt[i];
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; pkt[3] = 8'h44;
    arm(0);
    send_pkt(4);
    tick(2);
    for (int i = 0; i < 2; i++) begin
      e = model_data(i == 1, 0, 4, pkt);
      exp_last[i] = e;
      n_cmp += 3;
      if (nd_cnt[i] - nd0[i] != 1) begin n_err++; $display("FAIL clamp_pulses[%0d] got %0d want 1", i, nd_cnt[i] - nd0[i]); end
      if (nd_data[i] !== e) begin n_err++; $display("FAIL clamp_data[%0d] got %h want %h", i, nd_data[i], e); end
      if (nd_len[i] !== LW'(4)) begin n_err++; $display("FAIL clamp_len[%0d] got %0d want 4", i, nd_len[i]); end
      nd0[i] = nd_cnt[i];
      fe0[i] = fe_cnt[i];
    end
    exp_len_last = LW'(4);
    send_frame(8'h55, 1'b1);
    tick(4);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 3;
      if (nd_cnt[i] != nd0[i]) begin n_err++; $display("FAIL extra_frame_pulse[%0d] got %0d want %0d", i, nd_cnt[i], nd0[i]); end
      if (fe_cnt[i] != fe0[i]) begin n_err++; $display("FAIL extra_frame_err[%0d] got %0d want %0d", i, fe_cnt[i], fe0[i]); end
      if (data_o[i] !== exp_last[i]) begin n_err++; $display("FAIL extra_frame_data[%0d] got %h want %h", i, data_o[i], exp_last[i]); end
    end
  endtask

  task automatic test_timeout;
    int nd0 [2], to0 [2];
    logic [DW-1:0] e;
    for (int i = 0; i < 2; i++) begin nd0[i] = nd_cnt[i]; to0[i] = to_cnt[i]; end
    pkt[0] = 8'h11; pkt[1] = 8'h22;
    arm(4);
    send_frame(pkt[0], 1'b1);
    send_frame(pkt[1], 1'b1);
    tick(33 * CBR);
    for (int i = 0; i < 2; i++) begin
      e = model_data(i == 1, 4, 2, pkt);
      exp_last[i] = e;
      n_cmp += 6;
      if (to_cnt[i] - to0[i] != 1) begin n_err++; $display("FAIL tmo_pulses[%0d] got %0d want 1", i, to_cnt[i] - to0[i]); end
      if (nd_cnt[i] - nd0[i] != 1) begin n_err++; $display("FAIL tmo_nd[%0d] got %0d want 1", i, nd_cnt[i] - nd0[i]); end
      if (nd_data[i] !== e) begin n_err++; $display("FAIL tmo_data[%0d] got %h want %h", i, nd_data[i], e); end
      if (nd_len[i] !== LW'(2)) begin n_err++; $display("FAIL tmo_len[%0d] got %0d want 2", i, nd_len[i]); end
      if (excl_bad[i] != 0) begin n_err++; $display("FAIL tmo_exclusive[%0d] got %0d want 0", i, excl_bad[i]); end
      if (busy[i] !== 1'b0) begin n_err++; $display("FAIL tmo_busy[%0d] got %b want 0", i, busy[i]); end
    end
    exp_len_last = LW'(2);
  endtask

  task automatic test_frame_err;
    int nd0 [2], fe0 [2];
    for (int i = 0; i < 2; i++) begin nd0[i] = nd_cnt[i]; fe0[i] = fe_cnt[i]; end
    arm(2);
    send_frame(8'h5A, 1'b1);
    send_frame(8'h77, 1'b0);
    tick(4);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 5;
      if (fe_cnt[i] - fe0[i] != 1) begin n_err++; $display("FAIL ferr_pulses[%0d] got %0d want 1", i, fe_cnt[i] - fe0[i]); end
      if (nd_cnt[i] != nd0[i]) begin n_err++; $display("FAIL ferr_nd[%0d] got %0d want %0d", i, nd_cnt[i], nd0[i]); end
      if (busy[i] !== 1'b0) begin n_err++; $display("FAIL ferr_busy[%0d] got %b want 0", i, busy[i]); end
      if (data_o[i] !== exp_last[i]) begin n_err++; $display("FAIL ferr_data[%0d] got %h want %h", i, data_o[i], exp_last[i]); end
      if (len_o[i] !== exp_len_last) begin n_err++; $display("FAIL ferr_len[%0d] got %0d want %0d", i, len_o[i], exp_len_last); end
    end
  endtask

  task automatic test_late_arm;
    int nd0 [2];
    for (int i = 0; i < 2; i++) nd0[i] = nd_cnt[i];
    fork
      send_frame(8'hE7, 1'b1);
      begin tick(CBR); arm(1); end
    join
    tick(4);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 2;
      if (nd_cnt[i] != nd0[i]) begin n_err++; $display("FAIL late_arm_nd[%0d] got %0d want %0d", i, nd_cnt[i], nd0[i]); end
      if (busy[i] !== 1'b1) begin n_err++; $display("FAIL late_arm_busy[%0d] got %b want 1", i, busy[i]); end
    end
    pkt[0] = 8'h42;
    send_frame(pkt[0], 1'b1);
    tick(4);
    for (int i = 0; i < 2; i++) begin
      exp_last[i] = model_data(i == 1, 1, 1, pkt);
      n_cmp += 2;
      if (nd_cnt[i] - nd0[i] != 1) begin n_err++; $display("FAIL late_arm_pulses[%0d] got %0d want 1", i, nd_cnt[i] - nd0[i]); end
      if (nd_data[i] !== exp_last[i]) begin n_err++; $display("FAIL late_arm_data[%0d] got %h want %h", i, nd_data[i], exp_last[i]); end
    end
    exp_len_last = LW'(1);
  endtask

  task automatic test_random;
    int nd0 [2];
    int req, l;
    logic [DW-1:0] e;
    for (int p = 0; p < 8; p++) begin
      req = $urandom_range(0, 7);
      l = clamp_len(req);
      for (int k = 0; k < 8; k++) pkt[k] = 8'($urandom);
      for (int i = 0; i < 2; i++) nd0[i] = nd_cnt[i];
      arm(req);
      send_pkt(l);
      tick(2);
      for (int i = 0; i < 2; i++) begin
        e = model_data(i == 1, req, l, pkt);
        exp_last[i] = e;
        n_cmp += 3;
        if (nd_cnt[i] - nd0[i] != 1) begin n_err++; $display("FAIL rand%0d_pulses[%0d] got %0d want 1", p, i, nd_cnt[i] - nd0[i]); end
        if (nd_data[i] !== e) begin n_err++; $display("FAIL rand%0d_data[%0d] got %h want %h (req %0d)", p, i, nd_data[i], e, req); end
        if (nd_len[i] !== LW'(l)) begin n_err++; $display("FAIL rand%0d_len[%0d] got %0d want %0d", p, i, nd_len[i], l); end
      end
      exp_len_last = LW'(l);
    end
  endtask

  task automatic test_glitch_reset;
    int nd0 [2], fe0 [2], to0 [2];
    logic [DW-1:0] e;
    for (int i = 0; i < 2; i++) begin nd0[i] = nd_cnt[i]; fe0[i] = fe_cnt[i]; to0[i] = to_cnt[i]; end
    arm(2);
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(3 * CBR);
    send_frame(8'h99, 1'b1);
    tick(4);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 2;
      if (nd_cnt[i] != nd0[i]) begin n_err++; $display("FAIL glitch_nd[%0d] got %0d want %0d", i, nd_cnt[i], nd0[i]); end
      if (busy[i] !== 1'b1) begin n_err++; $display("FAIL glitch_busy[%0d] got %b want 1", i, busy[i]); end
    end
    rx = 1'b0;
    tick(CBR);
    rx = 1'b1;
    tick(CBR);
    rx = 1'b0;
    tick(10);
    rst = 1'b1;
    rx = 1'b1;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 3;
      if (data_o[i] !== '0) begin n_err++; $display("FAIL midrst_data[%0d] got %h want 0", i, data_o[i]); end
      if (len_o[i] !== '0) begin n_err++; $display("FAIL midrst_len[%0d] got %0d want 0", i, len_o[i]); end
      if (busy[i] !== 1'b0) begin n_err++; $display("FAIL midrst_busy[%0d] got %b want 0", i, busy[i]); end
    end
    rst = 1'b0;
    tick(2 * CBR);
    for (int i = 0; i < 2; i++) begin
      n_cmp += 3;
      if (nd_cnt[i] != nd0[i]) begin n_err++; $display("FAIL midrst_nd[%0d] got %0d want %0d", i, nd_cnt[i], nd0[i]); end
      if (fe_cnt[i] != fe0[i]) begin n_err++; $display("FAIL midrst_fe[%0d] got %0d want %0d", i, fe_cnt[i], fe0[i]); end
      if (to_cnt[i] != to0[i]) begin n_err++; $display("FAIL midrst_to[%0d] got %0d want %0d", i, to_cnt[i], to0[i]); end
    end
    pkt[0] = 8'($urandom); pkt[1] = 8'($urandom);
    arm(2);
    send_pkt(2);
    tick(2);
    for (int i = 0; i < 2; i++) begin
      e = model_data(i == 1, 2, 2, pkt);
      n_cmp += 3;
      if (nd_cnt[i] - nd0[i] != 1) begin n_err++; $display("FAIL post_rst_pulses[%0d] got %0d want 1", i, nd_cnt[i] - nd0[i]); end
      if (nd_data[i] !== e) begin n_err++; $display("FAIL post_rst_data[%0d] got %h want %h", i, nd_data[i], e); end
      if (nd_len[i] !== LW'(2)) begin n_err++; $display("FAIL post_rst_len[%0d] got %0d want 2", i, nd_len[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb_len3();
    test_clamp();
    test_timeout();
    test_frame_err();
    test_late_arm();
    test_random();
    test_glitch_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
